// File: rtl/ifetch_buffer.sv
// ---------------------------------------------------------------------------
// ifetch_buffer
//
// Instruction fetch front end placed ahead of the IF/ID register. It issues
// sequential word-aligned fetch requests to instruction memory and collects
// the in-order responses in a DEPTH-entry FIFO. The FIFO head is presented as
// instrF/PCF. A taken branch/jump from Execute (Redirect) flushes the FIFO,
// retargets fetch, and discards the responses that are still in flight.
//
// Requests are credit limited. Buffered entries plus outstanding requests
// never exceed DEPTH, so a returning response always finds a free slot.
//
// Ports
//   clk             clock
//   reset           synchronous, active-high reset
//   StallF          hold the head entry (no pop)
//   Redirect        taken branch/jump from Execute; overrides StallF
//   RedirectPC      redirect target; bits [1:0] are ignored
//   instrF          head instruction, NOP (addi x0,x0,0) when ValidF=0
//   PCF             PC of the head instruction, 0 when ValidF=0
//   ValidF          head entry holds a valid instruction
//   imem_req_valid  fetch request valid
//   imem_req_ready  instruction memory accepts the request
//   imem_addr       word-aligned fetch address
//   imem_resp_valid response valid (in order, one per accepted request)
//   imem_resp_data  response instruction word
// ---------------------------------------------------------------------------
module ifetch_buffer #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC,
    output logic [31:0]     instrF,
    output logic [XLEN-1:0] PCF,
    output logic            ValidF,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data
);

    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Fetch-side and response-side program counters.
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q,  resp_pc_d;

    // Occupancy counters, each in the range 0..DEPTH.
    logic [CW-1:0]   count_q,    count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q,  discard_d;

    // FIFO pointers; DEPTH is a power of two so they wrap naturally.
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    // FIFO storage: instruction word and its PC.
    logic [31:0]     data_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];

    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_pc_unused;

    // Compressed instructions are not supported, so the low target bits
    // carry no information.
    assign redirect_target    = {RedirectPC[XLEN-1:2], 2'b00};
    assign redirect_pc_unused = ^RedirectPC[1:0];

    // Credits come from registered state only, keeping imem_req_valid free
    // of any combinational path from the response channel.
    assign credit_used    = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req_valid = !reset && !Redirect && (credit_used < DEPTH_W);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only when no stale responses remain to be dropped
    // and no redirect is flushing the buffer in the same cycle.
    assign push = imem_resp_valid && !Redirect && (discard_q == '0);
    assign pop  = ValidF && !StallF && !Redirect;

    assign ValidF = (count_q != '0);
    assign instrF = ValidF ? data_q[rd_ptr_q] : NOP;
    assign PCF    = ValidF ? pc_q[rd_ptr_q]   : '0;

    always_comb begin
        // NOTE: every signal driven here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);

        if (Redirect) begin
            // No request fires in a redirect cycle, so inflight_d is just the
            // post-response count: every one of those responses is now stale.
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = inflight_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_resp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples the pre-edge values of the others.
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // NOTE: the FIFO storage has no reset; count_q gates every read, so the
    // contents are never observed before being written.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            data_q[wr_ptr_q] <= imem_resp_data;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    // A response with nothing outstanding would underflow the in-flight count.
    a_no_unrequested_resp : assert property (
        @(posedge clk) disable iff (reset) imem_resp_valid |-> (inflight_q != '0)
    );

endmodule

// File: tb/tb_ifetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_ifetch_buffer
//
// Bench for ifetch_buffer. The instruction memory model returns a hashed word
// per address with a configurable in-order latency. The reference model
// tracks the sequence of requested addresses, the buffered words (as a queue
// of PCs), the number of outstanding requests and how many returning
// responses are stale after a redirect. It then predicts every output in
// every cycle.
// ---------------------------------------------------------------------------
module tb_ifetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic        ValidF;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    always #5 clk = ~clk;

    ifetch_buffer #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .StallF          (StallF),
        .Redirect        (Redirect),
        .RedirectPC      (RedirectPC),
        .instrF          (instrF),
        .PCF             (PCF),
        .ValidF          (ValidF),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data)
    );

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];        // accepted requests awaiting their response
    logic [31:0] kept[$];      // PCs of buffered instructions, head first
    int          outstanding;
    int          stale;
    logic [31:0] fetch;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;

    // Values sampled in the most recent cycle, for directed checks.
    logic        s_valid;
    logic        s_req;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic [31:0] s_addr;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // advance the model, then step to just after the next rising edge.
    task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc,
                         input logic ready, input logic do_reset);
        logic exp_req;
        logic resp_now;
        logic do_pop;
        req_t r;
        int   lat;

        reset          = do_reset;
        StallF         = stall;
        Redirect       = redir;
        RedirectPC     = rpc;
        imem_req_ready = ready;
        resp_now        = !do_reset && (mq.size() > 0) && (mq[0].due <= cyc);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;

        @(negedge clk);
        s_valid = ValidF;
        s_req   = imem_req_valid;
        s_pc    = PCF;
        s_instr = instrF;
        s_addr  = imem_addr;

        exp_req = !do_reset && !redir && ((outstanding + kept.size()) < DEPTH);
        check("req_valid", imem_req_valid, exp_req);
        if (!do_reset) begin
            check("addr", imem_addr, fetch);
            check("valid", ValidF, kept.size() != 0);
            check("pc", PCF, (kept.size() != 0) ? kept[0] : 32'h0);
            check("instr", instrF, (kept.size() != 0) ? mem_word(kept[0]) : NOP);
        end

        if (do_reset) begin
            mq.delete();
            kept.delete();
            outstanding = 0;
            stale       = 0;
            fetch       = RESET_PC;
            last_due    = 0;
        end else begin
            do_pop = !redir && !stall && (kept.size() != 0);
            if (exp_req && ready) begin
                lat    = int'($urandom_range(lat_max, lat_min));
                r.addr = fetch;
                r.due  = cyc + lat;
                if (r.due <= last_due) r.due = last_due + 1;
                last_due = r.due;
                mq.push_back(r);
                outstanding++;
                fetch = fetch + 32'd4;
            end
            if (do_pop) void'(kept.pop_front());
            if (resp_now) begin
                r = mq.pop_front();
                outstanding--;
                if (!redir) begin
                    if (stale > 0) stale--;
                    else kept.push_back(r.addr);
                end
            end
            if (redir) begin
                kept.delete();
                stale = outstanding;
                fetch = {rpc[31:2], 2'b00};
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        stall;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        cyc = 0; last_due = 0; outstanding = 0; stale = 0; fetch = RESET_PC;
        lat_min = 1; lat_max = 1;
        reset = 1'b1; StallF = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;

        // Latency-1 memory, always ready, no stall, straight after reset.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h04};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h08};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0C};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h10};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h14};

        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].stall, 1'b0, 32'h0, vecs[i].ready, 1'b0);
            check("tbl_valid", s_valid, vecs[i].exp_valid);
            check("tbl_pc", s_pc, vecs[i].exp_pc);
            check("tbl_instr", s_instr, vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : NOP);
            check("tbl_req", s_req, vecs[i].exp_req);
            check("tbl_addr", s_addr, vecs[i].exp_addr);
        end

        // Stall six cycles: the buffer fills to DEPTH and requests stop.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check("stall_full_req", s_req, 1'b0);
        check("stall_full_valid", s_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            check("nobubble", s_valid, 1'b1);
        end

        // Drain, then build three outstanding requests with none returning.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        lat_min = 4; lat_max = 4;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outstanding == 3 && mq.size() > 0 && mq[0].due > cyc) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("wait_three_inflight", found, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("redir_flush_valid", s_valid, 1'b0);
        check("redir_first_addr", s_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            if (s_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("redir_valid_seen", found, 1'b1);
        check("redir_head_pc", s_pc, 32'h100);
        check("redir_head_instr", s_instr, mem_word(32'h100));

        // Redirect coinciding with a response while the head is stalled.
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (kept.size() > 0 && outstanding >= 2 && mq[0].due == cyc) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("wait_resp_collide", found, 1'b1);
        cycle(1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("collide_addr", s_addr, 32'h100);
        check("collide_req", s_req, 1'b1);
        check("collide_valid", s_valid, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Random ready, latency 1-4, stalls and redirects (some near the wrap).
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            logic        st, rd, rdy;
            logic [31:0] tgt;
            st  = ($urandom_range(3, 0) == 0);
            rdy = $urandom_range(1, 0) == 1;
            rd  = ($urandom_range(39, 0) == 0);
            tgt = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                              : ($urandom & 32'h000F_FFFF);
            cycle(st, rd, tgt, rdy, 1'b0);
        end

        // Misaligned redirect, then reset with two requests outstanding.
        lat_min = 4; lat_max = 4;
        cycle(1'b0, 1'b1, 32'h203, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("redir_align", s_addr, 32'h200);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outstanding == 2) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0, 32'h0, outstanding < 2, 1'b0);
        end
        check("wait_two_inflight", found, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("reset_req_low", s_req, 1'b0);
        lat_min = 1; lat_max = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("post_reset_valid", s_valid, 1'b0);
        check("post_reset_instr", s_instr, NOP);
        check("post_reset_pc", s_pc, 32'h0);
        check("post_reset_addr", s_addr, RESET_PC);
        check("post_reset_req", s_req, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
